quad_gen: RTL and testbench
===========================

# quad_gen

Quadrature waveform generator: accepts step commands (direction plus repeat count) and drives a two-phase Gray-coded A/B pair that emulates a 24-detent rotary encoder, one full four-phase cycle per detent. It drives the quadrature decoder input path directly for loopback self-test and bench stimulus, and can also feed external quadrature inputs. It keeps its own modulo-24 position that tracks what a matching decoder will count.

## Interface
- PHASE_DIV, 1000: clock cycles each A/B phase is held; legal range ≥1.
- MODULUS, 24: position wrap modulus; legal range ≤64.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_dir  in  1  1 = increment, 0 = decrement.
- cmd_steps  in  6  number of detents to emit, 0–63.
- stop  in  1  finish the current detent, then drop the remaining steps.
- quadA  out  1  phase A, registered.
- quadB  out  1  phase B, registered.
- busy  out  1  a step sequence is in progress.
- position  out  6  modulo-MODULUS detent position, registered.

## Operation
- Rest state: A=1, B=1 (detent).
- Increment detent, (A,B) order: 01, 00, 10, 11. The counted edge is B falling while A=0, entering phase 2.
- Decrement detent, (A,B) order: 10, 00, 01, 11. The counted edge is A falling while B=0, entering phase 2.
- FSM states:
  - IDLE: cmd_ready=1, busy=0. On accept with cmd_steps≠0: latch dir, set remaining=cmd_steps, go to PH1. On accept with cmd_steps=0: no effect, stay in IDLE.
  - PH1–PH4: each is held PHASE_DIV cycles.
  - After PH4 expires: decrement remaining. If remaining becomes 0, or a stop is pending, go to IDLE. Otherwise go to PH1.
- Position update: on entry to PH2, increment (MODULUS-1 wraps to 0) or decrement (0 wraps to MODULUS-1).
- stop: level-sampled each cycle while busy, then latched as pending. It never truncates a detent; the outputs always finish at 11. stop is ignored in IDLE, and pending stop clears on return to IDLE.
- cmd_valid is ignored while busy. No queuing.
- Reset values: quadA=1, quadB=1, position=0, busy=0, cmd_ready=1, FSM in IDLE, phase timer 0, remaining 0, stop pending cleared. Reset mid-sequence aborts immediately to these values.

## Timing
- Accept edge (cmd_valid & cmd_ready & steps≠0):
  - quadA/quadB take the PH1 value at that same edge.
  - busy goes 1 and cmd_ready goes 0 at that same edge.
- Each phase lasts exactly PHASE_DIV cycles. One detent lasts 4·PHASE_DIV cycles. N detents last 4·N·PHASE_DIV cycles with no gap between detents.
- Position changes PHASE_DIV cycles after the accept edge (entry to PH2), together with the A/B change.
- At the PH4 expiry edge ending the last detent: busy=0 and cmd_ready=1. A new command can be accepted on the next edge.
- Phase timer width is clog2(PHASE_DIV), minimum 1 bit. remaining is 6 bits.

## Structure
- Package quad_gen_pkg holds:
  - the state enum (IDLE, PH1–PH4);
  - the phase output constants for both directions;
  - the default MODULUS.
- One natural sub-module, phase_timer:
  - PHASE_DIV-cycle down-counter;
  - load on phase entry, single-cycle expire pulse, synchronous reset.
- Everything else is inline: FSM, remaining counter, stop latch, position counter.

## Test plan
All scenarios use PHASE_DIV=4, MODULUS=24.
- Reset:
  - stimulus: hold rst_n=0 for 3 cycles, then release;
  - required: quadA=1, quadB=1, position=0, cmd_ready=1, busy=0.
- Single increment:
  - stimulus: from position 0, issue dir=1, steps=1;
  - required: A/B = 01,00,10,11, each held 4 cycles; position=1 at accept+4; cmd_ready=1 at accept+16.
- Decrement wrap:
  - stimulus: from position 0, issue dir=0, steps=1;
  - required: A/B = 10,00,01,11; position=23 at accept+4.
- Full turn:
  - stimulus: from position 0, issue dir=1, steps=24;
  - required: 96 phases with no gap; position passes 23 and returns to 0; busy low at accept+384. Loopback into the decoder ends with its count at 0.
- Stop and zero count:
  - stimulus: dir=1, steps=5, with stop pulsed during detent 2;
  - required: detent 2 completes to 11, position=2, idle at accept+32.
  - stimulus: a later dir=1, steps=0;
  - required: no output change, busy stays 0.
- Reset mid-sequence:
  - stimulus: rst_n=0 during PH2 of a detent;
  - required: next edge quadA=1, quadB=1, position=0, FSM in IDLE; cmd_valid held high is not accepted until rst_n returns high.

Source files
------------

// File: rtl/quad_gen_pkg.sv
// rtl/quad_gen_pkg.sv - shared states, phase patterns and defaults for quad_gen
package quad_gen_pkg;

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4} state_t;

  localparam int DEFAULT_MODULUS   = 24;
  localparam int DEFAULT_PHASE_DIV = 1000;

  // {A,B} per phase; PH4 is always the detent rest pattern
  localparam logic [1:0] AB_REST    = 2'b11;
  localparam logic [1:0] AB_INC_PH1 = 2'b01;
  localparam logic [1:0] AB_INC_PH2 = 2'b00;
  localparam logic [1:0] AB_INC_PH3 = 2'b10;
  localparam logic [1:0] AB_DEC_PH1 = 2'b10;
  localparam logic [1:0] AB_DEC_PH2 = 2'b00;
  localparam logic [1:0] AB_DEC_PH3 = 2'b01;

  function automatic logic [1:0] phase_ab(input logic dir, input state_t st);
    logic [1:0] ab;
    ab = AB_REST;
    case (st)
      PH1:     ab = dir ? AB_INC_PH1 : AB_DEC_PH1;
      PH2:     ab = dir ? AB_INC_PH2 : AB_DEC_PH2;
      PH3:     ab = dir ? AB_INC_PH3 : AB_DEC_PH3;
      default: ab = AB_REST;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/quad_gen_if.sv
// rtl/quad_gen_if.sv - command and quadrature output bundle for quad_gen
interface quad_gen_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [5:0] cmd_steps;
  logic       stop;
  logic       quadA;
  logic       quadB;
  logic       busy;
  logic [5:0] position;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, stop,
    input  cmd_ready, quadA, quadB, busy, position
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, stop,
    output cmd_ready, quadA, quadB, busy, position
  );

endinterface

// File: rtl/quad_gen_phase_timer.sv
// rtl/quad_gen_phase_timer.sv - PHASE_DIV-cycle down-counter with expire pulse
module quad_gen_phase_timer #(
  parameter int PHASE_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(PHASE_DIV - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Reload coincides with expiry, so this is high for one cycle per phase
  assign expire = run && (cnt == '0);

endmodule

// File: rtl/quad_gen.sv
// rtl/quad_gen.sv - quadrature A/B step generator with modulo detent position
module quad_gen
  import quad_gen_pkg::*;
#(
  parameter int PHASE_DIV = DEFAULT_PHASE_DIV,
  parameter int MODULUS   = DEFAULT_MODULUS
) (
  input  logic       clk,
  input  logic       rst_n,
  quad_gen_if.slave  bus
);

  state_t     state, state_next;
  logic       dir_q, dir_next;
  logic [5:0] remaining, remaining_next;
  logic       stop_pend, stop_pend_next;
  logic [5:0] pos_q, pos_next;
  logic [1:0] ab_q, ab_next;
  logic       accept;
  logic       timer_load;
  logic       expire;

  assign accept = (state == IDLE) && bus.cmd_valid && (bus.cmd_steps != 6'd0);

  quad_gen_phase_timer #(.PHASE_DIV(PHASE_DIV)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .run    (state != IDLE),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      remaining <= 6'd0;
      stop_pend <= 1'b0;
      pos_q     <= 6'd0;
      ab_q      <= AB_REST;
    end else begin
      state     <= state_next;
      dir_q     <= dir_next;
      remaining <= remaining_next;
      stop_pend <= stop_pend_next;
      pos_q     <= pos_next;
      ab_q      <= ab_next;
    end
  end

  always_comb begin
    state_next     = state;
    dir_next       = dir_q;
    remaining_next = remaining;
    pos_next       = pos_q;
    timer_load     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          dir_next       = bus.cmd_dir;
          remaining_next = bus.cmd_steps;
          state_next     = PH1;
          timer_load     = 1'b1;
        end
      end
      PH1: begin
        if (expire) begin
          state_next = PH2;
          timer_load = 1'b1;
          // Position moves on the counted edge, which is the PH2 entry
          if (dir_q) begin
            pos_next = (pos_q == 6'(MODULUS - 1)) ? 6'd0 : pos_q + 6'd1;
          end else begin
            pos_next = (pos_q == 6'd0) ? 6'(MODULUS - 1) : pos_q - 6'd1;
          end
        end
      end
      PH2: begin
        if (expire) begin
          state_next = PH3;
          timer_load = 1'b1;
        end
      end
      PH3: begin
        if (expire) begin
          state_next = PH4;
          timer_load = 1'b1;
        end
      end
      PH4: begin
        if (expire) begin
          remaining_next = remaining - 6'd1;
          if ((remaining_next == 6'd0) || stop_pend) begin
            state_next = IDLE;
          end else begin
            state_next = PH1;
            timer_load = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    stop_pend_next = (state_next != IDLE) &&
                     (stop_pend || ((state != IDLE) && bus.stop));
    ab_next        = phase_ab(dir_next, state_next);
  end

  assign bus.quadA     = ab_q[1];
  assign bus.quadB     = ab_q[0];
  assign bus.busy      = (state != IDLE);
  assign bus.cmd_ready = (state == IDLE);
  assign bus.position  = pos_q;

endmodule

// File: tb/tb_quad_gen.sv
// tb/tb_quad_gen.sv - randomized self-checking bench for quad_gen
module tb_quad_gen;

  localparam int PD  = 4;
  localparam int MOD = 24;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   model_pos;
  int   dec_cnt;
  logic prev_a, prev_b;

  logic [1:0] inc_seq [4];
  logic [1:0] dec_seq [4];

  quad_gen_if bus ();

  quad_gen #(.PHASE_DIV(PD), .MODULUS(MOD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent decoder: B falls while A=0 counts up, A falls while B=0 counts down
  always @(negedge clk) begin
    if (!rst_n) begin
      dec_cnt = 0;
      prev_a  = 1'b1;
      prev_b  = 1'b1;
    end else begin
      if (prev_b && !bus.quadB && !bus.quadA) dec_cnt = dec_cnt + 1;
      if (prev_a && !bus.quadA && !bus.quadB) dec_cnt = dec_cnt - 1;
      prev_a = bus.quadA;
      prev_b = bus.quadB;
    end
  end

  function automatic int wrap(input int v);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  task automatic check_idle(input string name, input int exp_pos);
    logic [9:0] obs, exp;
    obs = {bus.quadA, bus.quadB, bus.busy, bus.cmd_ready, bus.position};
    exp = {2'b11, 1'b0, 1'b1, 6'(exp_pos)};
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got AB/busy/ready/pos=%b required %b", name, obs, exp);
    else
      n_pass++;
  endtask

  // Issue one command and check every cycle against the detent/phase arithmetic
  task automatic run_cmd(input bit dir, input int steps, input int stop_t, input string name);
    int n_eff, total, start, p, cnt, exp_pos;
    logic [1:0] exp_ab;
    logic exp_busy;
    logic [9:0] obs, exp;
    n_eff = steps;
    if (stop_t >= 0 && ((stop_t + 1) / (4 * PD)) + 1 < n_eff)
      n_eff = ((stop_t + 1) / (4 * PD)) + 1;
    total = 4 * PD * n_eff;
    start = model_pos;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_steps = 6'(steps);
    for (int t = 0; t <= total + 1; t++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.stop      = (t == stop_t);
      if (t < total) begin
        p        = (t / PD) % 4;
        cnt      = (t / (4 * PD)) + ((p >= 1) ? 1 : 0);
        exp_ab   = dir ? inc_seq[p] : dec_seq[p];
        exp_busy = 1'b1;
      end else begin
        cnt      = n_eff;
        exp_ab   = 2'b11;
        exp_busy = 1'b0;
      end
      exp_pos = dir ? wrap(start + cnt) : wrap(start - cnt);
      obs = {bus.quadA, bus.quadB, bus.busy, bus.cmd_ready, bus.position};
      exp = {exp_ab, exp_busy, ~exp_busy, 6'(exp_pos)};
      n_checks++;
      if (obs !== exp)
        $display("FAIL %s t=%0d: got AB/busy/ready/pos=%b required %b", name, t, obs, exp);
      else
        n_pass++;
    end
    bus.stop  = 1'b0;
    model_pos = dir ? wrap(start + n_eff) : wrap(start - n_eff);
    n_checks++;
    if (wrap(dec_cnt) != model_pos)
      $display("FAIL %s decoder: got count %0d required %0d", name, wrap(dec_cnt), model_pos);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_steps = 6'd0;
    bus.stop      = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_held", 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_released", 0);
    model_pos = 0;
  endtask

  task automatic test_single_and_wrap();
    run_cmd(1'b1, 1, -1, "single_inc");
    run_cmd(1'b0, 1, -1, "dec_back");
    run_cmd(1'b0, 1, -1, "dec_wrap");
    run_cmd(1'b1, 1, -1, "inc_wrap");
  endtask

  task automatic test_full_turn();
    run_cmd(1'b1, 24, -1, "full_turn");
  endtask

  task automatic test_stop_and_zero();
    int st;
    st = $urandom_range(8 * PD - 2, 4 * PD);
    if ((st + 1) % (4 * PD) == 0) st--;
    run_cmd(1'b1, 5, st, "stop_detent2");
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b1;
    bus.cmd_steps = 6'd0;
    bus.stop      = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_idle("zero_steps", model_pos);
    end
    bus.cmd_valid = 1'b0;
    bus.stop      = 1'b0;
    run_cmd(1'b1, 2, -1, "after_idle_stop");
  endtask

  task automatic test_random();
    int steps, st;
    bit dir;
    for (int i = 0; i < 8; i++) begin
      dir   = 1'($urandom_range(0, 1));
      steps = $urandom_range(1, 5);
      st    = -1;
      if ($urandom_range(0, 1) == 1) begin
        st = $urandom_range(4 * PD * steps - 2, 0);
        if ((st + 1) % (4 * PD) == 0) st--;
      end
      run_cmd(dir, steps, st, "random");
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ab;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b1;
    bus.cmd_steps = 6'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (PD + 1) @(negedge clk);
    ab = {bus.quadA, bus.quadB};
    n_checks++;
    if (ab !== 2'b00) $display("FAIL mid_ph2: got AB=%b required 00", ab);
    else n_pass++;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = 6'd2;
    @(negedge clk);
    check_idle("mid_reset_edge", 0);
    @(negedge clk);
    check_idle("mid_reset_held", 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    ab = {bus.quadA, bus.quadB};
    n_checks++;
    if (!bus.busy || ab !== 2'b01)
      $display("FAIL post_reset_accept: got busy=%b AB=%b required busy=1 AB=01", bus.busy, ab);
    else
      n_pass++;
    repeat (8 * PD) @(negedge clk);
    check_idle("post_reset_done", 2);
    n_checks++;
    if (wrap(dec_cnt) != 2)
      $display("FAIL post_reset_decoder: got count %0d required 2", wrap(dec_cnt));
    else
      n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    inc_seq  = '{2'b01, 2'b00, 2'b10, 2'b11};
    dec_seq  = '{2'b10, 2'b00, 2'b01, 2'b11};
    test_reset();
    test_single_and_wrap();
    test_full_turn();
    test_stop_and_zero();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
